// File: rtl/data_sramlike_bridge.sv
// Bridges the core's single-cycle SRAM data port onto an SRAM-like req/addr_ok/data_ok bus.
// Holds one transaction at a time, stalls the pipeline while it is in flight and keeps the load data until the pipeline moves.
module data_sramlike_bridge #(
    parameter bit READ_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        d_stall,
    input  logic        longest_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]  state_reg;
    logic        done_reg;
    logic [31:0] rdata_reg;
    logic        req_reg;
    logic        wr_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    logic        start;
    logic [1:0]  size_next;
    logic [31:0] addr_next;

    assign start = (state_reg == IDLE) && data_sram_en && !done_reg;

    // Illegal multi-byte patterns fall through to a word-sized request.
    always_comb begin
        size_next = 2'd2;
        case (data_sram_wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_next = 2'd0;
            4'b0011, 4'b1100:                   size_next = 2'd1;
            default:                            size_next = 2'd2;
        endcase
    end

    always_comb begin
        addr_next = data_sram_addr;
        if (READ_ALIGN && (data_sram_wen == 4'b0000)) begin
            addr_next = {data_sram_addr[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
            rdata_reg <= 32'd0;
            req_reg   <= 1'b0;
            wr_reg    <= 1'b0;
            size_reg  <= 2'd0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
        end else begin
            // done only lives in IDLE, so its release never races a completion.
            if (done_reg && !longest_stall) begin
                done_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= ADDR;
                        req_reg   <= 1'b1;
                        wr_reg    <= |data_sram_wen;
                        size_reg  <= size_next;
                        addr_reg  <= addr_next;
                        wdata_reg <= data_sram_wdata;
                    end
                end
                ADDR: begin
                    if (data_addr_ok) begin
                        req_reg <= 1'b0;
                        if (data_data_ok) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                            if (!wr_reg) begin
                                rdata_reg <= data_rdata;
                            end
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (data_data_ok) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        if (!wr_reg) begin
                            rdata_reg <= data_rdata;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign d_stall         = start || (state_reg == ADDR) || (state_reg == DATA);
    assign data_sram_rdata = rdata_reg;
    assign data_req        = req_reg;
    assign data_wr         = wr_reg;
    assign data_size       = size_reg;
    assign data_addr       = addr_reg;
    assign data_wdata      = wdata_reg;

endmodule

// File: tb/tb_data_sramlike_bridge.sv
// Transaction-level bench for data_sramlike_bridge: directed scenarios then randomized traffic
// with randomized slave latencies and foreign stalls, checked against a request/response model.
module tb_data_sramlike_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        i_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_rdata = 32'd0;

    always #5 clk = ~clk;

    // The pipeline-wide stall includes the bridge's own request.
    assign longest_stall = d_stall | i_stall;

    data_sramlike_bridge #(.READ_ALIGN(1'b1)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .d_stall         (d_stall),
        .longest_stall   (longest_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_size(input logic [3:0] wen);
        if (wen == 4'd0) return 2'd2;
        if ($countones(wen) == 1) return 2'd0;
        if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    // a = ADDR cycles before the one carrying addr_ok; d = DATA cycles (0 = combined ack);
    // fs = foreign-stall cycles after completion.
    task automatic txn(input string name, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int a, input int d, input int fs);
        logic [31:0] exp_addr;
        exp_addr = (wen == 4'd0) ? {addr[31:2], 2'b00} : addr;
        step();
        data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
        i_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        check({name, " issue d_stall"}, 32'(d_stall), 32'd1);
        check({name, " issue no req"}, 32'(data_req), 32'd0);
        for (int k = 0; k <= a; k++) begin
            step();
            data_addr_ok = (k == a);
            data_data_ok = (k == a) && (d == 0);
            data_rdata   = data_data_ok ? rdata : $urandom;
            #1;
            check({name, " addr req"}, 32'(data_req), 32'd1);
            check({name, " addr wr"}, 32'(data_wr), 32'(wen != 4'd0));
            check({name, " addr size"}, 32'(data_size), 32'(exp_size(wen)));
            check({name, " addr addr"}, data_addr, exp_addr);
            check({name, " addr wdata"}, data_wdata, wdata);
            check({name, " addr d_stall"}, 32'(d_stall), 32'd1);
        end
        for (int j = 1; j <= d; j++) begin
            step();
            data_addr_ok = 1'b0;
            data_data_ok = (j == d);
            data_rdata   = data_data_ok ? rdata : $urandom;
            #1;
            check({name, " data no req"}, 32'(data_req), 32'd0);
            check({name, " data d_stall"}, 32'(d_stall), 32'd1);
        end
        if (wen == 4'd0) model_rdata = rdata;
        for (int f = 0; f < fs; f++) begin
            step();
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom; i_stall = 1'b1;
            #1;
            check({name, " frozen d_stall"}, 32'(d_stall), 32'd0);
            check({name, " frozen no req"}, 32'(data_req), 32'd0);
            check({name, " frozen rdata"}, data_sram_rdata, model_rdata);
        end
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; i_stall = 1'b0;
        #1;
        check({name, " release d_stall"}, 32'(d_stall), 32'd0);
        check({name, " release no req"}, 32'(data_req), 32'd0);
        check({name, " release rdata"}, data_sram_rdata, model_rdata);
        $display("txn %s wen=%b addr=%08h a=%0d d=%0d fs=%0d rdata=%08h", name, wen, addr, a, d, fs,
                 data_sram_rdata);
    endtask

    task automatic idle_cycle();
        step();
        data_sram_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; i_stall = $urandom_range(0, 1);
        #1;
        check("idle d_stall", 32'(d_stall), 32'd0);
        check("idle no req", 32'(data_req), 32'd0);
        check("idle rdata", data_sram_rdata, model_rdata);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " req"}, 32'(data_req), 32'd0);
        check({name, " wr"}, 32'(data_wr), 32'd0);
        check({name, " size"}, 32'(data_size), 32'd0);
        check({name, " addr"}, data_addr, 32'd0);
        check({name, " wdata"}, data_wdata, 32'd0);
        check({name, " rdata"}, data_sram_rdata, 32'd0);
        check({name, " d_stall"}, 32'(d_stall), 32'd0);
    endtask

    logic [3:0] wen_tab [11] = '{4'h0, 4'h0, 4'h0, 4'hf, 4'h3, 4'hc, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5};

    initial begin
        resetn = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'd0;
        data_sram_wdata = 32'd0; i_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = 32'd0;
        step();
        step();
        check_all_zero("reset");
        resetn = 1'b1;

        txn("word_load", 4'b0000, 32'h1000_0006, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
        idle_cycle();
        txn("byte_store", 4'b0100, 32'h0000_0020, 32'h00AB_0000, 32'h1234_5678, 3, 1, 0);
        idle_cycle();
        txn("combined_ack", 4'b0000, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
        idle_cycle();
        txn("foreign_stall", 4'b0000, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 1, 2, 5);
        idle_cycle();

        // Reset while waiting for data_ok, then a stray data_ok.
        step();
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h300; i_stall = 1'b0;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; resetn = 1'b0; data_sram_en = 1'b0;
        #1;
        check("pre_reset in DATA d_stall", 32'(d_stall), 32'd1);
        step();
        resetn = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
        #1;
        check_all_zero("mid_reset");
        step();
        data_data_ok = 1'b0;
        #1;
        model_rdata = 32'd0;
        check_all_zero("stray_ok");

        txn("b2b_load", 4'b0000, 32'h0000_0408, 32'h0, 32'h1111_2222, 0, 1, 0);
        txn("b2b_half", 4'b1100, 32'h0000_040A, 32'hBEEF_0000, 32'h0, 0, 1, 0);
        idle_cycle();

        for (int n = 0; n < 40; n++) begin
            logic [3:0] w;
            w = wen_tab[$urandom_range(0, 10)];
            txn($sformatf("rand%0d", n), w, $urandom, $urandom, $urandom,
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
